// File: rtl/eta_adder_arbiter.sv
// Round-robin front end that shares one external error-tolerant adder between two
// requesters, holding operands for a multicycle settle window before capturing the sum.
//
// state   | meaning
// IDLE    | arbitrating; the winner's ready is high and its pair is accepted on the edge
// SETTLE  | operands held on the adder, counting down the settle window
// RESP    | captured sum presented on the response port until handshake
module eta_adder_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_add1_i,
  input  logic [WIDTH-1:0] req0_add2_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_add1_i,
  input  logic [WIDTH-1:0] req1_add2_i,
  output logic [WIDTH-1:0] adder_add1_o,
  output logic [WIDTH-1:0] adder_add2_o,
  input  logic [WIDTH:0]   adder_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH:0]   rsp_result_o,
  output logic             rsp_src_o,
  output logic             busy_o
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range
    $error("eta_adder_arbiter: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant;
  logic       grant_vld;

  // Contention goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    grant     = 1'b0;
    grant_vld = 1'b0;
    if (state == ST_IDLE) begin
      if (req0_valid_i && req1_valid_i) begin
        grant     = ~last_grant;
        grant_vld = 1'b1;
      end else if (req0_valid_i) begin
        grant     = 1'b0;
        grant_vld = 1'b1;
      end else if (req1_valid_i) begin
        grant     = 1'b1;
        grant_vld = 1'b1;
      end
    end
  end

  assign req0_ready_o = grant_vld && !grant;
  assign req1_ready_o = grant_vld && grant;
  assign busy_o       = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      last_grant   <= 1'b1;
      adder_add1_o <= '0;
      adder_add2_o <= '0;
      rsp_result_o <= '0;
      rsp_src_o    <= 1'b0;
      rsp_valid_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            adder_add1_o <= grant ? req1_add1_i : req0_add1_i;
            adder_add2_o <= grant ? req1_add2_i : req0_add2_i;
            rsp_src_o    <= grant;
            last_grant   <= grant;
            cnt          <= SETTLE_LOAD;
            state        <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt - 4'd1;
          // Capture on the last edge of the window; the carry bit passes through untouched.
          if (cnt == 4'd1) begin
            rsp_result_o <= adder_result_i;
            rsp_valid_o  <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_o <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eta_adder_arbiter.sv
// Randomized and directed bench for eta_adder_arbiter: a cycle-level reference model
// predicts readys, busy and the response, and a scoreboard checks each handshake.
module tb_eta_adder_arbiter;
  localparam int W = 32;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           v0, v1;
  logic [W-1:0]   a10, a20, a11, a21;
  logic           r0, r1;
  logic [W-1:0]   adder_add1, adder_add2;
  logic [W:0]     adder_result;
  logic           rsp_valid, rsp_ready, rsp_src, busy;
  logic [W:0]     rsp_result;

  logic           ov_en;
  logic [W:0]     ov_val;

  always #5 clk = ~clk;

  // Stub adder: exact sum unless a directed test forces the output.
  assign adder_result = ov_en ? ov_val : ({1'b0, adder_add1} + {1'b0, adder_add2});

  eta_adder_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(v0), .req0_ready_o(r0), .req0_add1_i(a10), .req0_add2_i(a20),
    .req1_valid_i(v1), .req1_ready_o(r1), .req1_add1_i(a11), .req1_add2_i(a21),
    .adder_add1_o(adder_add1), .adder_add2_o(adder_add2), .adder_result_i(adder_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_src_o(rsp_src), .busy_o(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: transaction phase tracked by edge counts, not FSM encoding.
  bit         m_busy, m_valid, m_last, m_src, bump, rec_acc;
  logic [W-1:0] m_op1, m_op2;
  logic [W:0] m_res;
  int         m_k;
  int         cyc = 0;
  int         acc_cyc[$];
  bit         q_src[$];
  logic [W:0] q_res[$];

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_last = 1; m_src = 0; m_k = 0;
    m_op1 = '0; m_op2 = '0; m_res = '0;
    q_src.delete(); q_res.delete();
  endtask

  task automatic check_regs();
    chk("busy", busy, m_busy);
    chk("rsp_valid", rsp_valid, m_valid);
    chk("adder_add1", adder_add1, m_op1);
    chk("adder_add2", adder_add2, m_op2);
    chk("rsp_src", rsp_src, m_src);
    chk("rsp_result", rsp_result, m_res);
  endtask

  // Called right after a negedge with inputs already driven; ends at the next negedge.
  task automatic tick();
    bit g, gv;
    #1;
    g = 0; gv = 0;
    if (!m_busy) begin
      if (v0 && v1) begin gv = 1; g = ~m_last; end
      else if (v0)  begin gv = 1; g = 0; end
      else if (v1)  begin gv = 1; g = 1; end
    end
    chk("req0_ready", r0, gv && !g);
    chk("req1_ready", r1, gv && g);
    if (gv) begin
      m_busy = 1; m_k = 0; m_src = g; m_last = g;
      m_op1 = g ? a11 : a10;
      m_op2 = g ? a21 : a20;
      if (rec_acc) acc_cyc.push_back(cyc);
    end else if (m_busy && !m_valid) begin
      m_k++;
      if (m_k == S) begin
        m_valid = 1;
        m_res = ov_en ? ov_val : ({1'b0, m_op1} + {1'b0, m_op2});
        q_src.push_back(m_src);
        q_res.push_back(m_res);
        if (bump) fork
          begin #5; ov_val = 33'h1_FFFF_FFFF; end
        join_none
      end
    end else if (m_valid && rsp_ready) begin
      m_valid = 0; m_busy = 0;
    end
    @(negedge clk);
    cyc++;
    check_regs();
  endtask

  task automatic drain();
    for (int i = 0; i < S + 4 && m_busy; i++) begin
      v0 = 0; v1 = 0; rsp_ready = 1;
      tick();
    end
    chk("drained_idle", busy, 1'b0);
  endtask

  task automatic wait_capture();
    for (int i = 0; i < S + 2 && !m_valid; i++) tick();
  endtask

  // Scoreboard monitor: pops one expectation per response handshake.
  always @(negedge clk) begin
    #2;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q_res.size() == 0) begin
        checks++; failures++;
        $display("FAIL scb_unexpected_rsp actual=%0h required=none", rsp_result);
      end else begin
        chk("scb_src", rsp_src, q_src.pop_front());
        chk("scb_result", rsp_result, q_res.pop_front());
      end
    end
  end

  initial begin
    rst_n = 0; v0 = 0; v1 = 0; rsp_ready = 0;
    a10 = '0; a20 = '0; a11 = '0; a21 = '0;
    ov_en = 0; ov_val = '0; bump = 0; rec_acc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_regs();
    chk("reset_req0_ready", r0, 1'b0);
    chk("reset_req1_ready", r1, 1'b0);
    rst_n = 1;

    // Lone req1 is ready in the same cycle despite last_grant=1.
    @(negedge clk);
    v1 = 1; a11 = 32'h1234_5678; a21 = 32'h1111_1111; rsp_ready = 1;
    #1 chk("first_req1_ready", r1, 1'b1);
    tick();
    drain();

    // Single operation with known sum.
    v0 = 1; a10 = 32'h0000_00FF; a20 = 32'h0000_0001; rsp_ready = 1;
    tick();
    v0 = 0;
    wait_capture();
    chk("single_sum", rsp_result, 33'h0_0000_0100);
    chk("single_src", rsp_src, 1'b0);
    drain();

    // Continuous contention: alternating grants, accepts S+2 edges apart.
    rec_acc = 1; rsp_ready = 1;
    for (int i = 0; i < 4 * (S + 2); i++) begin
      v0 = 1; v1 = 1;
      a10 = $urandom; a20 = $urandom; a11 = $urandom; a21 = $urandom;
      tick();
    end
    rec_acc = 0;
    chk("contention_accepts", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("accept_spacing", acc_cyc[i] - acc_cyc[i-1], S + 2);
    drain();

    // Adder output changes right after the capture edge; pre-edge value is kept.
    ov_en = 1; ov_val = 33'h1_FFFF_FFFE; bump = 1; rsp_ready = 0;
    v0 = 1; a10 = 32'hFFFF_FFFF; a20 = 32'hFFFF_FFFF;
    tick();
    v0 = 0;
    wait_capture();
    bump = 0;
    chk("capture_value", rsp_result, 33'h1_FFFF_FFFE);

    // Backpressure for 10 cycles with both requesters pending.
    for (int i = 0; i < 10; i++) begin
      v0 = 1; v1 = 1; a10 = $urandom; a11 = $urandom;
      rsp_ready = 0;
      tick();
    end
    chk("bp_still_valid", rsp_valid, 1'b1);
    v0 = 0; v1 = 0; rsp_ready = 1;
    tick();
    chk("bp_idle_after_hs", busy, 1'b0);
    ov_en = 0;

    // Reset asserted during SETTLE.
    v0 = 1; a10 = $urandom; a20 = $urandom; rsp_ready = 1;
    tick();
    v0 = 0;
    tick();
    rst_n = 0;
    #1;
    chk("settle_rst_busy", busy, 1'b0);
    chk("settle_rst_valid", rsp_valid, 1'b0);
    model_reset();
    #1 rst_n = 1;
    v1 = 1; a11 = $urandom; a21 = $urandom;
    tick();
    v1 = 0;
    drain();

    // Reset asserted during RESP.
    v0 = 1; a10 = $urandom; a20 = $urandom; rsp_ready = 0;
    tick();
    v0 = 0;
    wait_capture();
    rst_n = 0;
    #1;
    chk("resp_rst_valid", rsp_valid, 1'b0);
    chk("resp_rst_busy", busy, 1'b0);
    model_reset();
    #1 rst_n = 1;
    v0 = 1; v1 = 1; a10 = $urandom; a11 = $urandom;
    tick();
    v0 = 0; v1 = 0;
    drain();

    // Randomized traffic with withdrawals and random backpressure.
    for (int i = 0; i < 400; i++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      a10 = $urandom; a20 = $urandom; a11 = $urandom; a21 = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    chk("scb_empty", q_res.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eta_adder_arbiter.md
# eta_adder_arbiter

Round-robin scheduler that shares one combinational 32-bit error-tolerant adder between two requesters. It registers the winning operand pair onto the adder inputs and holds them for a programmable settle window, which treats the adder as a multicycle path. It then captures the 33-bit sum and presents it on a single valid/ready response port tagged with the source requester. It sits between the operand producers and the adder instance. The adder itself is external and connects through the `adder_*` ports.

## Interface
- `WIDTH`, 32, operand width; the result is `WIDTH+1` bits.
- `SETTLE_CYCLES`, 1, clock edges the adder inputs are held before the result is captured; legal range 1..15. A value of 0 is an elaboration error.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_ni`  input  1  reset, asynchronous and active-low.
- `req0_valid_i`  input  1  requester 0 has an operand pair.
- `req0_ready_o`  output  1  requester 0 pair accepted this cycle when `req0_valid_i` is also high.
- `req0_add1_i` / `req0_add2_i`  input  WIDTH  requester 0 operands.
- `req1_valid_i`, `req1_ready_o`, `req1_add1_i`, `req1_add2_i`  same meanings, for requester 1.
- `adder_add1_o` / `adder_add2_o`  output  WIDTH  registered operands to the adder.
- `adder_result_i`  input  WIDTH+1  adder sum output.
- `rsp_valid_o`  output  1  result available.
- `rsp_ready_i`  input  1  consumer accepts the result.
- `rsp_result_o`  output  WIDTH+1  captured sum.
- `rsp_src_o`  output  1  index of the requester that produced `rsp_result_o`.
- `busy_o`  output  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, SETTLE, RESP. There is also a 4-bit settle counter and a 1-bit `last_grant` register.
- **Arbitration (IDLE only), combinational:**
  - Only one requester valid: that requester wins.
  - Both valid: the requester not equal to `last_grant` wins.
  - Neither valid: no grant.
- **Ready:** `reqN_ready_o` = (state == IDLE) and (grant == N). Ready may depend on both valids. Ready is never high outside IDLE.
- **Accept edge** (IDLE, winner valid):
  - `adder_add1_o`/`adder_add2_o` load the winner operands.
  - `rsp_src_o` and `last_grant` load the winner index.
  - The counter loads `SETTLE_CYCLES`.
  - The state goes to SETTLE.
- **SETTLE:** each edge decrements the counter. On the edge where the counter equals 1:
  - `rsp_result_o` loads `adder_result_i`.
  - `rsp_valid_o` sets.
  - The state goes to RESP.
- **RESP:** all outputs are held. The edge with `rsp_ready_i`=1 clears `rsp_valid_o` and returns the state to IDLE. No accept occurs on that same edge.
- **Operand stability:** `adder_add*_o` change only on accept edges. Operands are never modified; the result is passed through unaltered, including its approximation error and bit WIDTH carry.
- **Input changes:** changes to requester inputs outside the accept edge have no effect.

## Timing
- **Reset values:**
  - state IDLE, counter 0, `last_grant`=1 (so requester 0 wins the first contention).
  - `adder_add1_o`, `adder_add2_o`, `rsp_result_o`, `rsp_src_o` = 0.
  - `rsp_valid_o`, `busy_o` = 0.
  - Both readys are 0 until the first valid arrives.
- **Latency:** accept at edge E0 gives `rsp_valid_o`=1 after edge E0+`SETTLE_CYCLES`. The adder sees new operands from E0 for exactly `SETTLE_CYCLES` full cycles before capture.
- **Throughput:** with `rsp_ready_i` held high, the minimum accept-to-accept spacing is `SETTLE_CYCLES`+2 edges.
- **Backpressure:** RESP holds indefinitely with stable `rsp_result_o`/`rsp_src_o`. Requesters stay not-ready for the whole time.
- **Simultaneous requests:** requests strictly alternate while both remain valid. A lone requester is granted back-to-back regardless of `last_grant`.
- **Valid withdrawn before accept:** a requester that drops valid before its accept edge loses no state. The next edge re-arbitrates.
- **Reset mid-operation:** asserting `rst_ni` low in SETTLE or RESP immediately (asynchronously) clears `rsp_valid_o`/`busy_o` and discards the transaction. The first cycle after deassertion is IDLE.
- **Busy:** `busy_o` rises after the accept edge and falls after the response handshake edge.

## Test plan
- **Reset:** hold `rst_ni`=0, then release → all outputs 0; state IDLE; first lone `req1_valid_i` sees `req1_ready_o`=1 in that same cycle.
- **Single op, `SETTLE_CYCLES`=1:** req0 drives 0x0000_00FF + 0x0000_0001, stub adder drives an exact sum → `rsp_valid_o` after 1 edge; `rsp_result_o`=0x0_0000_0100; `rsp_src_o`=0.
- **Contention, `SETTLE_CYCLES`=3:** both valid continuously with `rsp_ready_i`=1 → grants 0,1,0,1; accepts every 5 edges; each result appears 3 edges after its accept.
- **Capture edge:** stub adder changes `adder_result_i` from 0x1_FFFF_FFFE to 0x1_FFFF_FFFF at the exact capture edge → the value sampled at that edge is reported; carry bit 32 is preserved.
- **Backpressure:** `rsp_ready_i`=0 for 10 cycles → `rsp_valid_o`, `rsp_result_o`, `adder_add*_o` stable; both readys 0; handshake on cycle 11 → IDLE next cycle.
- **Mid-op reset:** assert `rst_ni` during SETTLE → `rsp_valid_o` and `busy_o` drop without a clock; after release, a pending req1 is granted first only if req0 is idle.
